// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order load/store queue between issue, result buses, ROB and dcache
//
// Ports:
//   clockIn, resetIn (async, active-high), clearIn (misprediction flush)
//   add*            : enqueue request from the instruction unit
//   rs*             : reservation-station result broadcast
//   robBegin*       : ROB head commit
//   accessType, readWriteOut, dataAddr, dataOut : dcache request (one-cycle pulse)
//   dataValid, dataIn, dataWriteSuc             : dcache response
//   lsb*            : load result broadcast
//   full, count     : occupancy
module load_store_queue #(
  parameter int ROB_WIDTH   = 4,
  parameter int LSQ_WIDTH   = 3,
  parameter int LSQ_SIZE    = 2**LSQ_WIDTH,
  parameter int OP_WIDTH    = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clearIn,
  input  logic                 addValid,
  input  logic                 addReadWrite,
  input  logic [ROB_WIDTH-1:0] addRobId,
  input  logic                 addBaseHasDep,
  input  logic [31:0]          addBase,
  input  logic [ROB_WIDTH-1:0] addBaseConstrtId,
  input  logic [31:0]          addOffset,
  input  logic                 addDataHasDep,
  input  logic [31:0]          addData,
  input  logic [ROB_WIDTH-1:0] addDataConstrtId,
  input  logic [OP_WIDTH-1:0]  addOp,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsUpdateVal,
  input  logic                 robBeginValid,
  input  logic [ROB_WIDTH-1:0] robBeginId,
  output logic [1:0]           accessType,
  output logic                 readWriteOut,
  output logic [31:0]          dataAddr,
  output logic [31:0]          dataOut,
  input  logic                 dataValid,
  input  logic [31:0]          dataIn,
  input  logic                 dataWriteSuc,
  output logic                 lsbUpdate,
  output logic [ROB_WIDTH-1:0] lsbRobIndex,
  output logic [31:0]          lsbUpdateVal,
  output logic                 full,
  output logic [LSQ_WIDTH:0]   count
);

  localparam logic [OP_WIDTH-1:0]  OP_B     = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0]  OP_H     = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0]  OP_BU    = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0]  OP_HU    = OP_WIDTH'(4);
  localparam logic [LSQ_WIDTH:0]   CNT_ONE  = (LSQ_WIDTH+1)'(1);
  localparam logic [LSQ_WIDTH:0]   CNT_SIZE = (LSQ_WIDTH+1)'(LSQ_SIZE);
  localparam logic [LSQ_WIDTH+1:0] SIZE_W   = (LSQ_WIDTH+2)'(LSQ_SIZE);
  localparam logic [LSQ_WIDTH+1:0] MARGIN_W = (LSQ_WIDTH+2)'(FULL_MARGIN);

  logic [LSQ_SIZE-1:0]  e_valid, e_committed, e_rw, e_base_dep, e_data_dep;
  logic [ROB_WIDTH-1:0] e_rob     [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] e_base_id [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] e_data_id [LSQ_SIZE];
  logic [31:0]          e_base    [LSQ_SIZE];
  logic [31:0]          e_data    [LSQ_SIZE];
  logic [31:0]          e_offset  [LSQ_SIZE];
  logic [OP_WIDTH-1:0]  e_op      [LSQ_SIZE];

  logic [LSQ_WIDTH-1:0] head, tail;
  logic [LSQ_WIDTH:0]   count_q;
  logic                 busy, drop_load;
  logic [OP_WIDTH-1:0]  lat_op;

  logic [31:0]          head_addr;
  logic                 head_ready, resp, do_issue, do_enq;
  logic [1:0]           head_size;
  logic [LSQ_SIZE-1:0]  commit_hit, keep_mask;
  logic [LSQ_WIDTH:0]   keep;
  logic [LSQ_WIDTH-1:0] idx;
  logic                 stop;

  assign count     = count_q;
  assign full      = ({1'b0, count_q} + MARGIN_W) >= SIZE_W;
  assign head_addr = e_base[head] + e_offset[head];
  assign resp      = dataValid | dataWriteSuc;
  // A response in the flush cycle belongs to a squashed load, so it is never broadcast.
  assign lsbUpdate = dataValid & ~drop_load & ~clearIn;

  // Loads to IO space (addr[17:16] == 11) must wait for commit; stores always do.
  assign head_ready = e_valid[head] && !e_base_dep[head] &&
                      (e_rw[head] ? (head_addr[17:16] != 2'b11 || e_committed[head])
                                  : (e_committed[head] && !e_data_dep[head]));
  assign do_issue = !clearIn && head_ready && (!busy || resp);
  assign do_enq   = !clearIn && addValid && (count_q != CNT_SIZE);

  always_comb begin
    head_size = 2'b11;
    case (e_op[head])
      OP_B, OP_BU: head_size = 2'b01;
      OP_H, OP_HU: head_size = 2'b10;
      default:     head_size = 2'b11;
    endcase
  end

  always_comb begin
    lsbUpdateVal = dataIn;
    case (lat_op)
      OP_B:    lsbUpdateVal = {{24{dataIn[7]}}, dataIn[7:0]};
      OP_H:    lsbUpdateVal = {{16{dataIn[15]}}, dataIn[15:0]};
      OP_BU:   lsbUpdateVal = {24'b0, dataIn[7:0]};
      OP_HU:   lsbUpdateVal = {16'b0, dataIn[15:0]};
      default: lsbUpdateVal = dataIn;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LSQ_SIZE; i++)
      commit_hit[i] = robBeginValid && e_valid[i] && (e_rob[i] == robBeginId);
  end

  // Committed prefix starting at head survives a flush; a commit arriving in the
  // flush cycle counts, since that instruction is older than the mispredict.
  always_comb begin
    keep      = '0;
    keep_mask = '0;
    stop      = 1'b0;
    idx       = '0;
    for (int i = 0; i < LSQ_SIZE; i++) begin
      idx = head + LSQ_WIDTH'(i);
      if (!stop && e_valid[idx] && (e_committed[idx] || commit_hit[idx])) begin
        keep_mask[idx] = 1'b1;
        keep           = keep + CNT_ONE;
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      busy         <= 1'b0;
      drop_load    <= 1'b0;
      lat_op       <= '0;
      accessType   <= 2'b00;
      readWriteOut <= 1'b1;
      dataAddr     <= '0;
      dataOut      <= '0;
      lsbRobIndex  <= '0;
      e_valid      <= '0;
      e_committed  <= '0;
      e_rw         <= '0;
      e_base_dep   <= '0;
      e_data_dep   <= '0;
      for (int i = 0; i < LSQ_SIZE; i++) begin
        e_rob[i]     <= '0;
        e_base_id[i] <= '0;
        e_data_id[i] <= '0;
        e_base[i]    <= '0;
        e_data[i]    <= '0;
        e_offset[i]  <= '0;
        e_op[i]      <= '0;
      end
    end else begin
      // Wakeup from either result bus; the RS bus has priority.
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (e_valid[i] && e_base_dep[i]) begin
          if (rsUpdate && rsRobIndex == e_base_id[i]) begin
            e_base[i] <= rsUpdateVal;  e_base_dep[i] <= 1'b0;
          end else if (lsbUpdate && lsbRobIndex == e_base_id[i]) begin
            e_base[i] <= lsbUpdateVal; e_base_dep[i] <= 1'b0;
          end
        end
        if (e_valid[i] && e_data_dep[i]) begin
          if (rsUpdate && rsRobIndex == e_data_id[i]) begin
            e_data[i] <= rsUpdateVal;  e_data_dep[i] <= 1'b0;
          end else if (lsbUpdate && lsbRobIndex == e_data_id[i]) begin
            e_data[i] <= lsbUpdateVal; e_data_dep[i] <= 1'b0;
          end
        end
        if (commit_hit[i]) e_committed[i] <= 1'b1;
      end

      accessType <= 2'b00;
      if (do_issue) begin
        accessType     <= head_size;
        readWriteOut   <= e_rw[head];
        dataAddr       <= head_addr;
        dataOut        <= e_data[head];
        lat_op         <= e_op[head];
        lsbRobIndex    <= e_rob[head];
        e_valid[head]  <= 1'b0;
        head           <= head + LSQ_WIDTH'(1);
      end

      if (do_issue)  busy <= 1'b1;
      else if (resp) busy <= 1'b0;

      // An in-flight load squashed by the flush: swallow its eventual response.
      if (clearIn && busy && readWriteOut && !resp) drop_load <= 1'b1;
      else if (dataValid)                             drop_load <= 1'b0;

      if (do_enq) begin
        e_valid[tail]     <= 1'b1;
        e_committed[tail] <= 1'b0;
        e_rw[tail]        <= addReadWrite;
        e_rob[tail]       <= addRobId;
        e_offset[tail]    <= addOffset;
        e_op[tail]        <= addOp;
        e_base_id[tail]   <= addBaseConstrtId;
        e_data_id[tail]   <= addDataConstrtId;
        if (!addBaseHasDep) begin
          e_base[tail] <= addBase;      e_base_dep[tail] <= 1'b0;
        end else if (rsUpdate && rsRobIndex == addBaseConstrtId) begin
          e_base[tail] <= rsUpdateVal;  e_base_dep[tail] <= 1'b0;
        end else if (lsbUpdate && lsbRobIndex == addBaseConstrtId) begin
          e_base[tail] <= lsbUpdateVal; e_base_dep[tail] <= 1'b0;
        end else begin
          e_base[tail] <= addBase;      e_base_dep[tail] <= 1'b1;
        end
        if (!addDataHasDep) begin
          e_data[tail] <= addData;      e_data_dep[tail] <= 1'b0;
        end else if (rsUpdate && rsRobIndex == addDataConstrtId) begin
          e_data[tail] <= rsUpdateVal;  e_data_dep[tail] <= 1'b0;
        end else if (lsbUpdate && lsbRobIndex == addDataConstrtId) begin
          e_data[tail] <= lsbUpdateVal; e_data_dep[tail] <= 1'b0;
        end else begin
          e_data[tail] <= addData;      e_data_dep[tail] <= 1'b1;
        end
        tail <= tail + LSQ_WIDTH'(1);
      end

      if (clearIn) begin
        for (int i = 0; i < LSQ_SIZE; i++)
          if (!keep_mask[i]) e_valid[i] <= 1'b0;
        tail    <= head + keep[LSQ_WIDTH-1:0];
        count_q <= keep;
      end else begin
        case ({do_enq, do_issue})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule
